// File: rtl/sqrt_arbiter.sv
// Round-robin front end that shares one fixed-latency, non-stallable sqrt core
// among N_REQ requesters. Admission is credit-based, so no core result is ever dropped.
module sqrt_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned LAT   = 17,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_data,
    output logic [N_REQ-1:0]   resp_valid,
    input  logic [N_REQ-1:0]   resp_ready,
    output logic [N_REQ*W-1:0] resp_data,
    output logic [W-1:0]       sqrt_data_in,
    output logic               sqrt_data_valid,
    input  logic [W-1:0]       sqrt_data_out,
    input  logic               sqrt_data_ready,
    output logic               busy,
    output logic               err_desync,
    output logic [31:0]        issue_count
);

    localparam int unsigned IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IDW-1:0]   ptr;
    logic [N_REQ-1:0] has_credit;
    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] grant_vec;
    logic [N_REQ-1:0] push;
    logic [N_REQ-1:0] pop;
    logic             grant_any;
    logic [IDW-1:0]   grant_id;
    int unsigned      search_idx;

    logic [LAT-1:0]   tag_valid;
    logic [IDW-1:0]   tag_id [LAT];
    logic             tail_valid;
    logic [IDW-1:0]   tail_id;

    assign eligible = req_valid & has_credit;

    // Search starts just after the last granted requester and wraps once around.
    always_comb begin
        grant_any  = 1'b0;
        grant_id   = '0;
        search_idx = 0;
        for (int unsigned j = 1; j <= N_REQ; j++) begin
            search_idx = 32'(ptr) + j;
            if (search_idx >= N_REQ) begin
                search_idx = search_idx - N_REQ;
            end
            if (!grant_any && eligible[IDW'(search_idx)]) begin
                grant_any = 1'b1;
                grant_id  = IDW'(search_idx);
            end
        end
    end

    always_comb begin
        grant_vec    = '0;
        sqrt_data_in = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_any && (grant_id == IDW'(i))) begin
                grant_vec[i] = 1'b1;
                sqrt_data_in = req_data[i*W +: W];
            end
        end
    end

    assign req_ready       = grant_vec;
    assign sqrt_data_valid = grant_any;

    // Owner tags travel alongside the core so the last stage lines up with sqrt_data_ready.
    always_ff @(posedge clock) begin
        if (reset) begin
            tag_valid <= '0;
        end else begin
            tag_valid[0] <= grant_any;
            for (int unsigned s = 1; s < LAT; s++) begin
                tag_valid[s] <= tag_valid[s-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        tag_id[0] <= grant_id;
        for (int unsigned s = 1; s < LAT; s++) begin
            tag_id[s] <= tag_id[s-1];
        end
    end

    assign tail_valid = tag_valid[LAT-1];
    assign tail_id    = tag_id[LAT-1];

    always_comb begin
        push = '0;
        pop  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            push[i] = sqrt_data_ready && tail_valid && (tail_id == IDW'(i));
            pop[i]  = resp_valid[i] && resp_ready[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr         <= IDW'(N_REQ - 1);
            issue_count <= '0;
            err_desync  <= 1'b0;
        end else begin
            if (grant_any) begin
                ptr         <= grant_id;
                issue_count <= issue_count + 32'd1;
            end
            if (sqrt_data_ready != tail_valid) begin
                err_desync <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_req
        logic [W-1:0]  mem [DEPTH];
        logic [PW-1:0] rd_ptr;
        logic [PW-1:0] wr_ptr;
        logic [CW-1:0] count;
        logic [CW-1:0] credit;

        // Credits mirror free FIFO space not yet claimed by in-flight operands.
        always_ff @(posedge clock) begin
            if (reset) begin
                credit <= CW'(DEPTH);
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (grant_vec[g] && !pop[g]) begin
                    credit <= credit - CW'(1);
                end else if (pop[g] && !grant_vec[g]) begin
                    credit <= credit + CW'(1);
                end
                if (push[g] && !pop[g]) begin
                    count <= count + CW'(1);
                end else if (pop[g] && !push[g]) begin
                    count <= count - CW'(1);
                end
                if (push[g]) begin
                    wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
                end
                if (pop[g]) begin
                    rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
                end
            end
        end

        always_ff @(posedge clock) begin
            if (push[g]) begin
                mem[wr_ptr] <= sqrt_data_out;
            end
        end

        assign has_credit[g]       = (credit != '0);
        assign resp_valid[g]       = (count != '0);
        assign resp_data[g*W +: W] = mem[rd_ptr];
    end

    assign busy = (|tag_valid) || (|resp_valid);

endmodule
